// File: rtl/game_pkg.sv
// Shared game-wide types and constants: facing directions, WASD keycodes,
// overworld status value and Frisk sprite box size.
package game_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  localparam logic [7:0] KEYCODE_W = 8'd26;
  localparam logic [7:0] KEYCODE_A = 8'd4;
  localparam logic [7:0] KEYCODE_S = 8'd22;
  localparam logic [7:0] KEYCODE_D = 8'd7;

  localparam logic [3:0] STATUS_OVERWORLD = 4'd3;

  localparam int FRISK_W = 38;
  localparam int FRISK_H = 58;

endpackage

// File: rtl/frisk_frame_map.sv
// Maps facing direction and walk phase to one of the ten Frisk sprite frames.
// Down/up walks alternate a standing frame with two stride frames.
module frisk_frame_map
  import game_pkg::*;
(
  input  dir_t       facing,
  input  logic [1:0] phase,
  output logic [3:0] frame_sel
);

  always_comb begin
    frame_sel = 4'd0;
    case (facing)
      DIR_DOWN: begin
        case (phase)
          2'd1:    frame_sel = 4'd1;
          2'd3:    frame_sel = 4'd2;
          default: frame_sel = 4'd0;
        endcase
      end
      DIR_UP: begin
        case (phase)
          2'd1:    frame_sel = 4'd4;
          2'd3:    frame_sel = 4'd5;
          default: frame_sel = 4'd3;
        endcase
      end
      DIR_LEFT:  frame_sel = phase[0] ? 4'd7 : 4'd6;
      DIR_RIGHT: frame_sel = phase[0] ? 4'd9 : 4'd8;
      default:   frame_sel = 4'd0;
    endcase
  end

endmodule

// File: rtl/frisk_anim_ctrl.sv
// Frisk walk-animation sequencer: frame_clk edge detect, facing/phase/divider
// state, sprite frame selection and a registered transparency-keyed pixel stage.
module frisk_anim_ctrl
  import game_pkg::*;
#(
  parameter int          ANIM_DIV   = 8,
  parameter logic [7:0]  KEY_UP     = KEYCODE_W,
  parameter logic [7:0]  KEY_LEFT   = KEYCODE_A,
  parameter logic [7:0]  KEY_DOWN   = KEYCODE_S,
  parameter logic [7:0]  KEY_RIGHT  = KEYCODE_D,
  parameter logic [3:0]  OVERWORLD  = STATUS_OVERWORLD,
  parameter logic [23:0] TRANSP_RGB = 24'h000000
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic [7:0]       keycode,
  input  logic [3:0]       status,
  input  logic             is_frisk,
  input  logic [19:0]      frisk_address,
  input  logic [9:0][23:0] rom_color,
  output logic [19:0]      rom_address,
  output logic [3:0]       frame_sel,
  output logic             frisk_draw,
  output logic [23:0]      frisk_color,
  output dir_t             dbg_facing,
  output logic [1:0]       dbg_phase,
  output logic [7:0]       dbg_div
);

  localparam logic [7:0] DIV_LAST = 8'(ANIM_DIV - 1);

  // armed stays low for the first cycle after reset so a frame_clk already high
  // at release is absorbed into fc_q instead of looking like a rising edge.
  logic fc_q, armed, fe;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fc_q  <= 1'b0;
      armed <= 1'b0;
      fe    <= 1'b0;
    end else begin
      fc_q  <= frame_clk;
      armed <= 1'b1;
      fe    <= armed & frame_clk & ~fc_q;
    end
  end

  dir_t       dir_req;
  logic       dir_none;
  dir_t       facing_q, facing_d;
  logic [1:0] phase_q, phase_d;
  logic [7:0] div_q, div_d;
  logic [3:0] frame_d;

  always_comb begin
    dir_req  = facing_q;
    dir_none = 1'b0;
    case (keycode)
      KEY_UP:    dir_req = DIR_UP;
      KEY_LEFT:  dir_req = DIR_LEFT;
      KEY_DOWN:  dir_req = DIR_DOWN;
      KEY_RIGHT: dir_req = DIR_RIGHT;
      default:   dir_none = 1'b1;
    endcase
  end

  // A direction change restarts the walk even if the divider is at terminal count.
  always_comb begin
    facing_d = facing_q;
    phase_d  = phase_q;
    div_d    = div_q;
    if (fe) begin
      if (status != OVERWORLD) begin
        facing_d = DIR_DOWN;
        phase_d  = 2'd0;
        div_d    = 8'd0;
      end else if (dir_none) begin
        phase_d = 2'd0;
        div_d   = 8'd0;
      end else if (dir_req != facing_q) begin
        facing_d = dir_req;
        phase_d  = 2'd0;
        div_d    = 8'd0;
      end else if (div_q == DIV_LAST) begin
        div_d   = 8'd0;
        phase_d = phase_q + 2'd1;
      end else begin
        div_d = div_q + 8'd1;
      end
    end
  end

  frisk_frame_map u_frame_map (
    .facing    (facing_d),
    .phase     (phase_d),
    .frame_sel (frame_d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      facing_q  <= DIR_DOWN;
      phase_q   <= 2'd0;
      div_q     <= 8'd0;
      frame_sel <= 4'd0;
    end else begin
      facing_q  <= facing_d;
      phase_q   <= phase_d;
      div_q     <= div_d;
      frame_sel <= frame_d;
    end
  end

  logic [23:0] sel_color;
  logic        draw_d;

  always_comb begin
    sel_color = (frame_sel < 4'd10) ? rom_color[frame_sel] : 24'h000000;
    draw_d    = is_frisk && (status == OVERWORLD) && (sel_color != TRANSP_RGB);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      frisk_draw  <= 1'b0;
      frisk_color <= 24'h000000;
    end else begin
      frisk_draw  <= draw_d;
      frisk_color <= draw_d ? sel_color : 24'h000000;
    end
  end

  assign rom_address = frisk_address;
  assign dbg_facing  = facing_q;
  assign dbg_phase   = phase_q;
  assign dbg_div     = div_q;

endmodule

// File: tb/tb_frisk_anim_ctrl.sv
// Bench for frisk_anim_ctrl: directed walk scenarios plus random key/status
// sequences checked against a rule-level walk model and a pixel expectation queue.
module tb_frisk_anim_ctrl;
  import game_pkg::*;

  localparam int ANIM_DIV = 8;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             frame_clk;
  logic [7:0]       keycode;
  logic [3:0]       status;
  logic             is_frisk;
  logic [19:0]      frisk_address;
  logic [9:0][23:0] rom_color;
  logic [19:0]      rom_address;
  logic [3:0]       frame_sel;
  logic             frisk_draw;
  logic [23:0]      frisk_color;
  dir_t             dbg_facing;
  logic [1:0]       dbg_phase;
  logic [7:0]       dbg_div;

  frisk_anim_ctrl #(.ANIM_DIV(ANIM_DIV)) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .keycode       (keycode),
    .status        (status),
    .is_frisk      (is_frisk),
    .frisk_address (frisk_address),
    .rom_color     (rom_color),
    .rom_address   (rom_address),
    .frame_sel     (frame_sel),
    .frisk_draw    (frisk_draw),
    .frisk_color   (frisk_color),
    .dbg_facing    (dbg_facing),
    .dbg_phase     (dbg_phase),
    .dbg_div       (dbg_div)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  logic [24:0] exp_q[$];

  // Walk model: facing 0=up 1=down 2=left 3=right, frames looked up from tables.
  int m_face, m_phase, m_div;
  int down_tbl[4] = '{0, 1, 0, 2};
  int up_tbl[4]   = '{3, 4, 3, 5};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_frame();
    case (m_face)
      0:       return up_tbl[m_phase];
      1:       return down_tbl[m_phase];
      2:       return 6 + (m_phase % 2);
      default: return 8 + (m_phase % 2);
    endcase
  endfunction

  function automatic void model_reset();
    m_face = 1; m_phase = 0; m_div = 0;
  endfunction

  function automatic void model_fe(input int key, input int st);
    int req;
    req = (key == 26) ? 0 : (key == 22) ? 1 : (key == 4) ? 2 : (key == 7) ? 3 : -1;
    if (st != 3) begin
      m_face = 1; m_phase = 0; m_div = 0;
    end else if (req < 0) begin
      m_phase = 0; m_div = 0;
    end else if (req != m_face) begin
      m_face = req; m_phase = 0; m_div = 0;
    end else if (m_div == ANIM_DIV - 1) begin
      m_div = 0; m_phase = (m_phase + 1) % 4;
    end else begin
      m_div = m_div + 1;
    end
  endfunction

  // One frame_clk period with keycode/status held; then compare walk state.
  task automatic tick();
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
    model_fe(int'(keycode), int'(status));
    chk("frame_sel", 32'(frame_sel), 32'(model_frame()));
    chk("phase", 32'(dbg_phase), 32'(m_phase));
    chk("div", 32'(dbg_div), 32'(m_div));
    chk("facing", 32'(dbg_facing), 32'(m_face));
  endtask

  // Present one pixel; the registered result is compared one Clk later.
  task automatic pixel(input logic is, input logic [23:0] col);
    logic d;
    for (int i = 0; i < 10; i++) rom_color[i] = 24'($urandom_range(1, 24'hffffff));
    rom_color[model_frame()] = col;
    is_frisk = is;
    frisk_address = 20'($urandom);
    d = is && (status == 4'd3) && (col != 24'h0);
    exp_q.push_back({d, d ? col : 24'h0});
    #1;
    chk("rom_address", 32'(rom_address), 32'(frisk_address));
    @(negedge Clk);
    begin
      logic [24:0] e;
      e = exp_q.pop_front();
      chk("frisk_draw", 32'(frisk_draw), 32'(e[24]));
      chk("frisk_color", 32'(frisk_color), 32'(e[23:0]));
    end
    is_frisk = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_clk = 1'b0; keycode = 8'd22; status = 4'd3;
    is_frisk = 1'b0; frisk_address = '0; rom_color = '0;
    model_reset();

    // Reset with frame_clk toggling, released while frame_clk is high.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      frame_clk = ~frame_clk;
    end
    frame_clk = 1'b1;
    @(negedge Clk);
    chk("rst_frame", 32'(frame_sel), 32'd0);
    chk("rst_draw", 32'(frisk_draw), 32'd0);
    chk("rst_color", 32'(frisk_color), 32'd0);
    Reset = 1'b0;
    repeat (4) @(negedge Clk);
    chk("no_fe_release", 32'(dbg_div), 32'd0);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);

    // Walk down for four phase advances.
    keycode = 8'd22;
    repeat (33) tick();

    // Walk left 9 edges, then release.
    keycode = 8'd4;
    repeat (9) tick();
    chk("left_stride", 32'(frame_sel), 32'd7);
    keycode = 8'd0;
    repeat (2) tick();
    chk("left_idle", 32'(frame_sel), 32'd6);

    // Direction change on the divider terminal count.
    keycode = 8'd26;
    repeat (8) tick();
    chk("up_term", 32'(dbg_div), 32'(ANIM_DIV - 1));
    keycode = 8'd7;
    tick();
    chk("chg_frame", 32'(frame_sel), 32'd8);
    chk("chg_div", 32'(dbg_div), 32'd0);

    // Pixel path, opaque and transparent.
    pixel(1'b1, 24'hffc90e);
    pixel(1'b1, 24'h000000);
    pixel(1'b0, 24'h123456);

    // Leaving overworld suppresses drawing and resets to facing down.
    status = 4'd2;
    pixel(1'b1, 24'hffc90e);
    tick();
    chk("nonow_frame", 32'(frame_sel), 32'd0);
    status = 4'd3;

    // Reset mid-walk.
    keycode = 8'd7;
    repeat (10) tick();
    for (int i = 0; i < 10; i++) rom_color[i] = 24'h00ff00;
    is_frisk = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("midrst_frame", 32'(frame_sel), 32'd0);
    chk("midrst_draw", 32'(frisk_draw), 32'd0);
    chk("midrst_color", 32'(frisk_color), 32'd0);
    chk("midrst_div", 32'(dbg_div), 32'd0);
    Reset = 1'b0; is_frisk = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);

    // Random key/status runs.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: keycode = 8'd26;
        1: keycode = 8'd4;
        2: keycode = 8'd22;
        3: keycode = 8'd7;
        4: keycode = 8'd0;
        default: keycode = 8'($urandom);
      endcase
      status = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd3;
      repeat ($urandom_range(1, 12)) tick();
      pixel(1'($urandom), ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
